// File: rtl/data_bus_responder_if.sv
// Purpose : cpu data-memory bus plus LED and TX byte-stream signals, bundled.
// Latency : n/a (signal bundle only).
// Backpressure: tx_ready from the stream sink stalls the TX FIFO head.
// Ports   : mem_addr/mem_wdata/mem_write (cpu -> responder), mem_rdata (responder -> cpu),
//           led (responder -> board), tx_data/tx_valid (responder -> sink), tx_ready (sink -> responder).
interface data_bus_responder_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic [7:0]  led;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  // cpu / sink side
  modport master (
    output mem_addr, mem_wdata, mem_write, tx_ready,
    input  mem_rdata, led, tx_data, tx_valid
  );

  // responder side
  modport slave (
    input  mem_addr, mem_wdata, mem_write, tx_ready,
    output mem_rdata, led, tx_data, tx_valid
  );
endinterface

// File: rtl/data_bus_responder.sv
// Purpose : data-memory responder: word RAM + MMIO (LED, cycle timer, TX byte FIFO, status).
// Latency : reads return exactly 1 cycle after the address is presented (read-first on RAM).
// Backpressure: TX FIFO head holds while tx_ready=0; pushes to a full FIFO drop and set sticky overflow.
// Ports   : clk, reset (sync, active-high), bus (data_bus_responder_if.slave).
module data_bus_responder #(
  parameter int RAM_AW   = 10,
  parameter int TX_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  data_bus_responder_if.slave  bus
);
  localparam int PW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int CW = $clog2(TX_DEPTH + 1);
  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [CW-1:0] C_FULL = CW'(TX_DEPTH);

  // ---------------- address decode ----------------
  logic              sel_mmio;
  logic [1:0]        reg_sel;
  logic [RAM_AW-1:0] ram_idx;
  logic              sel_led, sel_timer, sel_tx, sel_status;
  logic              unused_addr_bits;

  assign sel_mmio   = bus.mem_addr[31];
  assign reg_sel    = bus.mem_addr[3:2];
  assign ram_idx    = bus.mem_addr[RAM_AW+1:2];
  assign sel_led    = sel_mmio && (reg_sel == 2'd0);
  assign sel_timer  = sel_mmio && (reg_sel == 2'd1);
  assign sel_tx     = sel_mmio && (reg_sel == 2'd2);
  assign sel_status = sel_mmio && (reg_sel == 2'd3);
  // Aliased address bits are deliberately ignored.
  assign unused_addr_bits = ^{bus.mem_addr[30:RAM_AW+2], bus.mem_addr[1:0]};

  // ---------------- RAM (not reset) ----------------
  logic [31:0] ram [2**RAM_AW];
  logic [31:0] ram_rd_q;

  // Read and write in one process: the nonblocking write makes the read see the old word.
  always_ff @(posedge clk) begin
    ram_rd_q <= ram[ram_idx];
    if (bus.mem_write && !sel_mmio) ram[ram_idx] <= bus.mem_wdata;
  end

  // ---------------- MMIO state ----------------
  logic [7:0]    led_q, led_d;
  logic [31:0]   timer_q, timer_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   mmio_rd_q, mmio_rd_d;
  logic          sel_ram_q, sel_ram_d;
  logic [7:0]    fifo_mem [TX_DEPTH];

  logic       full, empty, push, pop, push_acc;
  logic [5:0] status_cnt;

  assign full       = (count_q == C_FULL);
  assign empty      = (count_q == '0);
  assign push       = bus.mem_write && sel_tx;
  assign pop        = !empty && bus.tx_ready;
  // A push into a full FIFO still lands when a pop frees the head slot the same edge.
  assign push_acc   = push && (!full || pop);
  assign status_cnt = 6'(count_q);

  always_comb begin
    led_d      = led_q;
    timer_d    = timer_q + 32'd1;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    mmio_rd_d  = 32'd0;
    sel_ram_d  = !sel_mmio;

    if (bus.mem_write && sel_led)   led_d   = bus.mem_wdata[7:0];
    if (bus.mem_write && sel_timer) timer_d = bus.mem_wdata;

    if (push_acc) wr_ptr_d = wr_ptr_q + P_ONE;
    if (pop)      rd_ptr_d = rd_ptr_q + P_ONE;
    case ({push_acc, pop})
      2'b10:   count_d = count_q + C_ONE;
      2'b01:   count_d = count_q - C_ONE;
      default: count_d = count_q;
    endcase

    // Clear first so a simultaneous drop (set) takes priority.
    if (bus.mem_write && sel_status && bus.mem_wdata[8]) overflow_d = 1'b0;
    if (push && full && !pop)                            overflow_d = 1'b1;

    // Read mux uses pre-edge state, so TIMER/STATUS reads see values before this edge's update.
    case (reg_sel)
      2'd0:    mmio_rd_d = {24'd0, led_q};
      2'd1:    mmio_rd_d = timer_q;
      2'd2:    mmio_rd_d = 32'd0;
      default: mmio_rd_d = {23'd0, overflow_q, full, empty, status_cnt};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q      <= '0;
      timer_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      mmio_rd_q  <= '0;
      sel_ram_q  <= 1'b0;
    end else begin
      led_q      <= led_d;
      timer_q    <= timer_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      mmio_rd_q  <= mmio_rd_d;
      sel_ram_q  <= sel_ram_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_acc && !reset) fifo_mem[wr_ptr_q] <= bus.mem_wdata[7:0];
  end

  // sel_ram_q resets to 0 so mem_rdata comes out of reset as the zeroed MMIO register.
  assign bus.mem_rdata = sel_ram_q ? ram_rd_q : mmio_rd_q;
  assign bus.led       = led_q;
  assign bus.tx_data   = fifo_mem[rd_ptr_q];
  assign bus.tx_valid  = !empty;
endmodule

// File: tb/tb_data_bus_responder.sv
module tb_data_bus_responder;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  localparam logic [31:0] A_LED    = 32'h8000_0000;
  localparam logic [31:0] A_TIMER  = 32'h8000_0004;
  localparam logic [31:0] A_TXDATA = 32'h8000_0008;
  localparam logic [31:0] A_STATUS = 32'h8000_000C;

  data_bus_responder_if bus();

  data_bus_responder #(.RAM_AW(10), .TX_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs and outputs change/settle 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w);
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    bus.mem_write = w;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(32'h0, 32'h0, 1'b0);
    bus.tx_ready = 1'b0;
    cyc(); cyc();
    checks++; if (bus.mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=%h", bus.mem_rdata, 32'h0); end
    checks++; if (bus.led !== 8'h0) begin errors++; $display("FAIL reset_led got=%h exp=%h", bus.led, 8'h0); end
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%b exp=0", bus.tx_valid); end
    reset = 1'b0;
    drive(A_TIMER, 32'h0, 1'b0);
    cyc();
    checks++; if (bus.mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_timer got=%h exp=%h", bus.mem_rdata, 32'h0); end
    drive(A_STATUS, 32'h0, 1'b0);
    cyc();
    checks++; if (bus.mem_rdata !== 32'h0000_0040) begin errors++; $display("FAIL reset_status got=%h exp=%h", bus.mem_rdata, 32'h40); end
  endtask

  task automatic test_ram();
    drive(32'h0000_0010, 32'hDEAD_BEEF, 1'b1); cyc();
    drive(32'h0000_0010, 32'h0, 1'b0); cyc();
    checks++; if (bus.mem_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_read got=%h exp=%h", bus.mem_rdata, 32'hDEADBEEF); end
    drive(32'h0000_1010, 32'h0, 1'b0); cyc();
    checks++; if (bus.mem_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_alias got=%h exp=%h", bus.mem_rdata, 32'hDEADBEEF); end
    drive(32'h0000_0013, 32'h0, 1'b0); cyc();
    checks++; if (bus.mem_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_lowbits got=%h exp=%h", bus.mem_rdata, 32'hDEADBEEF); end
  endtask

  task automatic test_read_first();
    drive(32'h20, 32'h5, 1'b1); cyc();
    drive(32'h20, 32'h1, 1'b1); cyc();
    checks++; if (bus.mem_rdata !== 32'h5) begin errors++; $display("FAIL rfw_old got=%h exp=%h", bus.mem_rdata, 32'h5); end
    drive(32'h20, 32'h0, 1'b0); cyc();
    checks++; if (bus.mem_rdata !== 32'h1) begin errors++; $display("FAIL rfw_new got=%h exp=%h", bus.mem_rdata, 32'h1); end
  endtask

  task automatic test_timer();
    drive(A_TIMER, 32'hFFFF_FFFE, 1'b1); cyc();
    drive(A_TIMER, 32'h0, 1'b0); cyc();
    checks++; if (bus.mem_rdata !== 32'hFFFF_FFFE) begin errors++; $display("FAIL timer_load got=%h exp=%h", bus.mem_rdata, 32'hFFFFFFFE); end
    cyc();
    checks++; if (bus.mem_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL timer_inc got=%h exp=%h", bus.mem_rdata, 32'hFFFFFFFF); end
    cyc();
    checks++; if (bus.mem_rdata !== 32'h0) begin errors++; $display("FAIL timer_wrap got=%h exp=%h", bus.mem_rdata, 32'h0); end
  endtask

  task automatic test_led();
    drive(A_LED, 32'hFFFF_FFA5, 1'b1); cyc();
    checks++; if (bus.led !== 8'hA5) begin errors++; $display("FAIL led_port got=%h exp=%h", bus.led, 8'hA5); end
    drive(A_LED, 32'h0, 1'b0); cyc();
    checks++; if (bus.mem_rdata !== 32'h0000_00A5) begin errors++; $display("FAIL led_read got=%h exp=%h", bus.mem_rdata, 32'hA5); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43; exp_b[3] = 8'h44;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(A_TXDATA, 32'h41 + i, 1'b1); cyc();
    end
    drive(A_STATUS, 32'h0, 1'b0); cyc();
    checks++; if (bus.mem_rdata !== 32'h0000_0184) begin errors++; $display("FAIL ovf_status got=%h exp=%h", bus.mem_rdata, 32'h184); end
    drive(A_TXDATA, 32'h0, 1'b0); cyc();
    checks++; if (bus.mem_rdata !== 32'h0) begin errors++; $display("FAIL txdata_read got=%h exp=%h", bus.mem_rdata, 32'h0); end
    drive(A_STATUS, 32'h100, 1'b1); cyc();
    drive(A_STATUS, 32'h0, 1'b0); cyc();
    checks++; if (bus.mem_rdata !== 32'h0000_0084) begin errors++; $display("FAIL ovf_clear got=%h exp=%h", bus.mem_rdata, 32'h84); end
    checks++; if (bus.tx_data !== 8'h41) begin errors++; $display("FAIL tx_hold got=%h exp=%h", bus.tx_data, 8'h41); end
    drive(32'h0, 32'h0, 1'b0);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp_b[i]) begin
        errors++; $display("FAIL drain_%0d got=%b/%h exp=1/%h", i, bus.tx_valid, bus.tx_data, exp_b[i]);
      end
      cyc();
    end
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", bus.tx_valid); end
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h62; exp_b[1] = 8'h63; exp_b[2] = 8'h64; exp_b[3] = 8'h55;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(A_TXDATA, 32'h61 + i, 1'b1); cyc();
    end
    drive(A_TXDATA, 32'h55, 1'b1);
    bus.tx_ready = 1'b1;
    cyc();
    bus.tx_ready = 1'b0;
    drive(A_STATUS, 32'h0, 1'b0); cyc();
    checks++; if (bus.mem_rdata !== 32'h0000_0084) begin errors++; $display("FAIL fullpp_status got=%h exp=%h", bus.mem_rdata, 32'h84); end
    drive(32'h0, 32'h0, 1'b0);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp_b[i]) begin
        errors++; $display("FAIL fullpp_%0d got=%b/%h exp=1/%h", i, bus.tx_valid, bus.tx_data, exp_b[i]);
      end
      cyc();
    end
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL fullpp_empty got=%b exp=0", bus.tx_valid); end
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    // Push and pop together while not full keeps count constant.
    bus.tx_ready = 1'b0;
    drive(A_TXDATA, 32'h71, 1'b1); cyc();
    bus.tx_ready = 1'b1;
    drive(A_TXDATA, 32'h72, 1'b1); cyc();
    bus.tx_ready = 1'b0;
    drive(A_STATUS, 32'h0, 1'b0); cyc();
    checks++; if (bus.mem_rdata !== 32'h0000_0001) begin errors++; $display("FAIL b2b_status got=%h exp=%h", bus.mem_rdata, 32'h1); end
    checks++; if (bus.tx_data !== 8'h72) begin errors++; $display("FAIL b2b_head got=%h exp=%h", bus.tx_data, 8'h72); end
    bus.tx_ready = 1'b1;
    drive(32'h0, 32'h0, 1'b0); cyc();
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    drive(A_LED, 32'hA5, 1'b1); cyc();
    drive(A_TXDATA, 32'h11, 1'b1); cyc();
    drive(A_TXDATA, 32'h22, 1'b1); cyc();
    drive(32'h0, 32'h0, 1'b0); cyc();
    checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got=%b exp=1", bus.tx_valid); end
    reset = 1'b1; cyc(); reset = 1'b0;
    checks++; if (bus.led !== 8'h0) begin errors++; $display("FAIL mid_reset_led got=%h exp=%h", bus.led, 8'h0); end
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got=%b exp=0", bus.tx_valid); end
    drive(A_TIMER, 32'h0, 1'b0); cyc();
    checks++; if (bus.mem_rdata !== 32'h0) begin errors++; $display("FAIL mid_reset_timer got=%h exp=%h", bus.mem_rdata, 32'h0); end
    drive(32'h10, 32'h0, 1'b0); cyc();
    checks++; if (bus.mem_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_keep10 got=%h exp=%h", bus.mem_rdata, 32'hDEADBEEF); end
    drive(32'h20, 32'h0, 1'b0); cyc();
    checks++; if (bus.mem_rdata !== 32'h1) begin errors++; $display("FAIL ram_keep20 got=%h exp=%h", bus.mem_rdata, 32'h1); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_read_first();
    test_timer();
    test_led();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
